// File: rtl/conv11_ctrl.sv
// ============================================================================
// Module      : conv11_ctrl
// Description : Sequencer for a 3x3 stride-1 convolution: walks every window
//               of an IMG_W x IMG_H frame in raster order, handshaking with
//               the line buffer and the MAC unit. Optional stall counter is
//               enabled by defining CONV11_CTRL_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv11_ctrl #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   win_req,
    input  logic                   win_ack,
    output logic [CNT_WIDTH-1:0]   win_row,
    output logic [CNT_WIDTH-1:0]   win_col,
    output logic                   calc_start,
    input  logic                   calc_done,
    output logic [2*CNT_WIDTH-1:0] out_count
`ifdef CONV11_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_fetch = 3'd1;
    localparam logic [2:0] c_calc  = 3'd2;
    localparam logic [2:0] c_wait  = 3'd3;
    localparam logic [2:0] c_next  = 3'd4;
    localparam logic [2:0] c_fin   = 3'd5;

    localparam logic [CNT_WIDTH-1:0] c_last_col = CNT_WIDTH'(IMG_W - 3);
    localparam logic [CNT_WIDTH-1:0] c_last_row = CNT_WIDTH'(IMG_H - 3);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_row;
    logic [CNT_WIDTH-1:0]   r_col;
    logic [2*CNT_WIDTH-1:0] r_count;
    logic                   w_start;
    logic                   w_last;

    assign w_start = (r_state == c_idle) && frame_start && !abort;
    assign w_last  = (r_col == c_last_col) && (r_row == c_last_row);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != c_idle);
        win_req     = (r_state == c_fetch);
        calc_start  = (r_state == c_calc);
        // An abort in FIN suppresses the completion pulse
        frame_done  = (r_state == c_fin) && !abort;
        if (abort) begin
            w_state_nxt = c_idle;
        end else begin
            case (r_state)
                c_idle:  if (frame_start) w_state_nxt = c_fetch;
                c_fetch: if (win_ack)     w_state_nxt = c_calc;
                c_calc:                   w_state_nxt = c_wait;
                c_wait:  if (calc_done)   w_state_nxt = c_next;
                c_next:  w_state_nxt = w_last ? c_fin : c_fetch;
                c_fin:                    w_state_nxt = c_idle;
                default:                  w_state_nxt = c_idle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_count <= '0;
        end else if (w_start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_count <= '0;
        end else if (!abort) begin
            if ((r_state == c_wait) && calc_done) begin
                r_count <= r_count + (2*CNT_WIDTH)'(1);
            end
            // Last window leaves row/col parked on the final position
            if ((r_state == c_next) && !w_last) begin
                if (r_col == c_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + CNT_WIDTH'(1);
                end else begin
                    r_col <= r_col + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign win_row   = r_row;
    assign win_col   = r_col;
    assign out_count = r_count;

`ifdef CONV11_CTRL_STALL_CNT_EN
    logic [15:0] r_stall;
    logic        w_stall_ev;

    assign w_stall_ev = ((r_state == c_fetch) && !win_ack) ||
                        ((r_state == c_wait)  && !calc_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_start) begin
            r_stall <= '0;
        end else if (w_stall_ev && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

`default_nettype wire

// File: doc/conv11_ctrl.md
CONV11_CTRL -- requirements
Module: conv11_ctrl

Interface
REQ-001 Parameter IMG_W, default 28, input feature-map width in pixels; legal range 3..2**CNT_WIDTH-1.
REQ-002 Parameter IMG_H, default 28, input feature-map height in pixels; legal range 3..2**CNT_WIDTH-1.
REQ-003 Parameter CNT_WIDTH, default 8, width of the row, column and output counters.
REQ-004 Port clk, input, 1, single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port frame_start, input, 1, single-cycle request to process one frame.
REQ-007 Port abort, input, 1, synchronous cancel of the current frame.
REQ-008 Port busy, output, 1, high in every state except IDLE.
REQ-009 Port frame_done, output, 1, one-cycle pulse when the last window of a frame completes.
REQ-010 Port win_req, output, 1, request to the line buffer to present the 3x3 window at win_row/win_col.
REQ-011 Port win_ack, input, 1, the window data is stable at the calc inputs.
REQ-012 Port win_row, output, CNT_WIDTH, top row of the current window.
REQ-013 Port win_col, output, CNT_WIDTH, left column of the current window.
REQ-014 Port calc_start, output, 1, drives start of the 3x3 MAC unit.
REQ-015 Port calc_done, input, 1, done from the MAC unit (valid_out && ready_in).
REQ-016 Port out_count, output, CNT_WIDTH*2, number of windows completed in the current frame.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, CALC, WAIT, NEXT and FIN.
REQ-018 In IDLE, when frame_start=1, the block SHALL clear win_row, win_col and out_count and enter FETCH on the next cycle.
REQ-019 In FETCH, win_req SHALL be 1; when win_ack=1, the block SHALL enter CALC; win_row and win_col SHALL stay constant while win_req=1.
REQ-020 In CALC, calc_start SHALL be 1 for exactly one cycle, then the block SHALL enter WAIT.
REQ-021 In WAIT, calc_start SHALL be 0; when calc_done=1, the block SHALL increment out_count and enter NEXT; WAIT has no timeout.
REQ-022 In NEXT, if win_col==IMG_W-3 and win_row==IMG_H-3, the block SHALL enter FIN.
REQ-023 In NEXT, otherwise, if win_col==IMG_W-3, it SHALL set win_col=0 and win_row=win_row+1, else win_col=win_col+1, then enter FETCH.
REQ-024 In FIN, frame_done SHALL be 1 for one cycle, then the block SHALL enter IDLE; out_count SHALL hold its final value until the next accepted frame_start.
REQ-025 A full frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) calc_start pulses, in raster order, with stride 1 and no padding.
REQ-026 frame_start outside IDLE SHALL be ignored, including in FIN.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle, with no frame_done; win_req and calc_start SHALL be 0 from that cycle.
REQ-028 If abort and frame_start are both 1 in IDLE, abort SHALL win and the frame SHALL not start.
REQ-029 calc_done outside WAIT SHALL be ignored and SHALL not change out_count.
REQ-030 Minimum latency per window SHALL be 4 cycles: FETCH with immediate ack, CALC, WAIT with immediate done, and NEXT.

Reset
REQ-031 While rst=1, the state SHALL be IDLE and busy, frame_done, win_req and calc_start SHALL be 0.
REQ-032 While rst=1, win_row, win_col, out_count and stall_cnt (if present) SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a new frame_start.

Configuration
REQ-034 Macro CONV11_CTRL_STALL_CNT_EN, when defined, SHALL add output stall_cnt, 16 bits, counting the cycles spent in FETCH with win_ack=0 plus the cycles in WAIT with calc_done=0.
REQ-035 stall_cnt SHALL saturate at 16'hFFFF and SHALL be cleared on an accepted frame_start.
REQ-036 Without CONV11_CTRL_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-037 IMG_W=IMG_H=5, win_ack and calc_done returned immediately -> 9 calc_start pulses at (row,col)=(0,0),(0,1),(0,2),(1,0)..(2,2); frame_done once; out_count=9.
REQ-038 Same configuration, win_ack delayed 3 cycles on every window -> win_row and win_col stable during win_req; 9 windows; stall_cnt=27 when the macro is defined.
REQ-039 abort asserted in WAIT of the 4th window -> IDLE on the next cycle, no frame_done, out_count=3; a following frame_start runs a full 9-window frame.
REQ-040 frame_start pulsed while busy and in FIN, and a spurious calc_done in FETCH -> no restart; out_count is unaffected.
REQ-041 rst asserted mid-frame at window 5 -> all outputs 0 immediately; no activity after release until frame_start.
